// File: rtl/slv_i2c_line_cond.sv
// slv_i2c_line_cond: SCL/SDA conditioning, edge/mid-phase strobes, START/STOP.
// Optional glitch filter compiled in with `define SLV_I2C_GLITCH_FLT_EN.
`timescale 1ns/1ps
module slv_i2c_line_cond #(
    parameter int CNT_SZ   = 10,
    parameter int FLT_LEN  = 3,
    parameter int HALF_DEF = 125
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic I_IO_SCL,
    input  logic I_IO_SDA,
    output logic O_SCL,
    output logic O_SDA,
    output logic O_RS_IO_SCL,
    output logic O_FL_IO_SCL,
    output logic O_RS_IO_SDA,
    output logic O_FL_IO_SDA,
    output logic O_MDL_LW_IO_SCL,
    output logic O_MDL_HG_IO_SCL,
    output logic O_START,
    output logic O_STOP,
    output logic O_BUS_BUSY
);

    localparam logic [CNT_SZ-1:0] LEN_DEF = CNT_SZ'(2 * HALF_DEF);
    localparam logic [CNT_SZ-1:0] CNT_MAX = '1;

    if (FLT_LEN < 1) begin : g_flt_len_chk
        $error("FLT_LEN must be at least 1");
    end

    // bit 0 carries SCL, bit 1 carries SDA
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] lvl;
    logic [1:0] lvl_d;
    logic [1:0] rs;
    logic [1:0] fl;

    // two-flop synchronizers, idle-high out of reset
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {I_IO_SDA, I_IO_SCL};
            sync2 <= sync1;
        end
    end

`ifdef SLV_I2C_GLITCH_FLT_EN
    localparam int FW = (FLT_LEN > 1) ? $clog2(FLT_LEN) : 1;
    localparam logic [FW-1:0] FLT_LAST = FW'(FLT_LEN - 1);

    logic [1:0][FW-1:0] flt_cnt;
    logic [1:0]         flt_q;

    // take a new level only after FLT_LEN consecutive differing samples
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            flt_cnt <= '0;
            flt_q   <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == flt_q[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_LAST) begin
                    flt_q[i]   <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = flt_q;
`else
    assign lvl = sync2;
`endif

    // previous conditioned levels, for edge detection
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            lvl_d <= 2'b11;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rs = lvl & ~lvl_d;
    assign fl = ~lvl & lvl_d;

    logic [CNT_SZ-1:0] lo_cnt;
    logic [CNT_SZ-1:0] hi_cnt;
    logic [CNT_SZ-1:0] lo_len;
    logic [CNT_SZ-1:0] hi_len;
    logic [CNT_SZ-1:0] lo_half;
    logic [CNT_SZ-1:0] hi_half;
    logic [CNT_SZ-1:0] lo_tgt;
    logic [CNT_SZ-1:0] hi_tgt;
    logic              bus_busy;

    // SCL phase counters and the length of the last complete phase
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            lo_cnt <= '0;
            hi_cnt <= '0;
            lo_len <= LEN_DEF;
            hi_len <= LEN_DEF;
        end else begin
            if (fl[0]) begin
                lo_cnt <= '0;
            end else if (!lvl[0] && lo_cnt != CNT_MAX) begin
                lo_cnt <= lo_cnt + 1'b1;
            end
            if (rs[0]) begin
                hi_cnt <= '0;
            end else if (lvl[0] && hi_cnt != CNT_MAX) begin
                hi_cnt <= hi_cnt + 1'b1;
            end
            if (rs[0]) begin
                lo_len <= lo_cnt;
            end
            if (fl[0]) begin
                hi_len <= hi_cnt;
            end
        end
    end

    assign lo_half = lo_len >> 1;
    assign hi_half = hi_len >> 1;
    assign lo_tgt  = (lo_half == '0) ? CNT_SZ'(1) : lo_half;
    assign hi_tgt  = (hi_half == '0) ? CNT_SZ'(1) : hi_half;

    // bus is busy from START until STOP
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            bus_busy <= 1'b0;
        end else if (O_START) begin
            bus_busy <= 1'b1;
        end else if (O_STOP) begin
            bus_busy <= 1'b0;
        end
    end

    assign O_SCL           = lvl[0];
    assign O_SDA           = lvl[1];
    assign O_RS_IO_SCL     = rs[0];
    assign O_FL_IO_SCL     = fl[0];
    assign O_RS_IO_SDA     = rs[1];
    assign O_FL_IO_SDA     = fl[1];
    assign O_MDL_LW_IO_SCL = ~lvl[0] & ~fl[0] & (lo_cnt == lo_tgt);
    assign O_MDL_HG_IO_SCL = lvl[0] & ~rs[0] & (hi_cnt == hi_tgt);
    // SDA edge only counts while SCL was high and is not falling now
    assign O_START         = fl[1] & lvl_d[0] & ~fl[0];
    assign O_STOP          = rs[1] & lvl_d[0] & ~fl[0];
    assign O_BUS_BUSY      = bus_busy;

endmodule
